// File: rtl/reaction_pkg.sv
// reaction_pkg
// Shared types and constants for the reaction-time tester sequencer.
//   state_t    : sequencer states (IDLE, DELAY, TIMING, DONE, FOUL)
//   LFSR_TAPS  : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   ELAPSED_W  : width of the binary elapsed-tick count
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_TIMING,
        ST_DONE,
        ST_FOUL
    } state_t;

    // Bit n-1 set for each tap n: 16,14,13,11 -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int ELAPSED_W = 14;

endpackage

// File: rtl/reaction_lfsr16.sv
// reaction_lfsr16
// Free-running 16-bit Fibonacci LFSR, advancing every clock.
// Parameters:
//   SEED   : reset value, must be non-zero
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, loads SEED
//   o_lfsr : current LFSR register value
module reaction_lfsr16
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = ^(r_lfsr & LFSR_TAPS);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_lfsr <= SEED;
        else       r_lfsr <= {r_lfsr[14:0], w_fb};
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/reaction_sequencer.sv
// reaction_sequencer
// Central FSM of the reaction-time tester: IDLE -> pseudo-random DELAY ->
// TIMING -> DONE (stop or timeout) or FOUL (stop during DELAY).
// Optional macro: REACTION_BEST_SCORE_EN adds best_time/best_valid, the
// fastest non-timeout result since reset.
// Ports:
//   CLOCK_50     : 50 MHz clock
//   reset        : synchronous active-high reset
//   request_test : start button level (rising edge starts a test)
//   stop_test    : stop button level (rising edge stops / fouls)
//   tick_100th   : one-cycle 10 ms strobe
//   waiting      : high in DELAY
//   test_active  : high in TIMING
//   bcd_clear    : one-cycle pulse as a test starts
//   bcd_enable   : tick_100th while in TIMING (combinational)
//   result_valid : high in DONE
//   timeout      : high in DONE when the test hit TIMEOUT_TICKS
//   foul         : high in FOUL
//   elapsed      : binary tick count of the current/last test
//   best_time, best_valid : (REACTION_BEST_SCORE_EN only) best result
module reaction_sequencer
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY_TICKS = 200,
    parameter int          RAND_BITS       = 8,
    parameter int          TIMEOUT_TICKS   = 9999,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 request_test,
    input  logic                 stop_test,
    input  logic                 tick_100th,
    output logic                 waiting,
    output logic                 test_active,
    output logic                 bcd_clear,
    output logic                 bcd_enable,
    output logic                 result_valid,
    output logic                 timeout,
    output logic                 foul,
    output logic [ELAPSED_W-1:0] elapsed
`ifdef REACTION_BEST_SCORE_EN
    ,
    output logic [ELAPSED_W-1:0] best_time,
    output logic                 best_valid
`endif
);

    localparam int DCW = $clog2(MIN_DELAY_TICKS + 2**RAND_BITS);
    localparam logic [ELAPSED_W-1:0] TIMEOUT_VAL = ELAPSED_W'(TIMEOUT_TICKS);

    state_t               r_state;
    logic                 r_req_q;
    logic                 r_stop_q;
    logic [DCW-1:0]       r_delay_cnt;
    logic [ELAPSED_W-1:0] r_elapsed;
    logic                 r_timeout;
    logic                 r_bcd_clear;

    logic [15:0]          w_lfsr;
    logic                 w_unused_lfsr;
    logic                 w_req_edge;
    logic                 w_stop_edge;
    logic [ELAPSED_W-1:0] w_elapsed_inc;
    logic                 w_tick_to;
    logic [DCW-1:0]       w_delay_load;

    reaction_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk  (CLOCK_50),
        .i_rst  (reset),
        .o_lfsr (w_lfsr)
    );

    // Only the low RAND_BITS feed the delay; the rest is just LFSR state.
    assign w_unused_lfsr = ^w_lfsr[15:RAND_BITS];

    assign w_req_edge    = request_test & ~r_req_q;
    assign w_stop_edge   = stop_test & ~r_stop_q;
    assign w_elapsed_inc = r_elapsed + ELAPSED_W'(1);
    // The tick that lands elapsed on the limit ends the test, even if a stop
    // edge arrives in the same cycle.
    assign w_tick_to     = tick_100th && (w_elapsed_inc == TIMEOUT_VAL);
    assign w_delay_load  = DCW'(MIN_DELAY_TICKS) + DCW'(w_lfsr[RAND_BITS-1:0]);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req_q     <= 1'b0;
            r_stop_q    <= 1'b0;
            r_delay_cnt <= '0;
            r_elapsed   <= '0;
            r_timeout   <= 1'b0;
            r_bcd_clear <= 1'b0;
        end else begin
            r_req_q     <= request_test;
            r_stop_q    <= stop_test;
            r_bcd_clear <= 1'b0;
            case (r_state)
                // Stop edges are ignored here; a start edge always wins.
                ST_IDLE, ST_DONE, ST_FOUL: begin
                    if (w_req_edge) begin
                        r_state     <= ST_DELAY;
                        r_delay_cnt <= w_delay_load;
                        r_elapsed   <= '0;
                        r_timeout   <= 1'b0;
                        r_bcd_clear <= 1'b1;
                    end
                end
                // Early stop beats a coincident final tick. Leaving on the
                // tick that sees count==1 gives exactly N ticks of wait.
                ST_DELAY: begin
                    if (w_stop_edge) begin
                        r_state <= ST_FOUL;
                    end else if (tick_100th) begin
                        if (r_delay_cnt <= DCW'(1)) begin
                            r_state     <= ST_TIMING;
                            r_delay_cnt <= '0;
                        end else begin
                            r_delay_cnt <= r_delay_cnt - DCW'(1);
                        end
                    end
                end
                // A tick coincident with stop is still counted so elapsed
                // tracks the BCD counter, which sees bcd_enable that cycle.
                ST_TIMING: begin
                    if (tick_100th) r_elapsed <= w_elapsed_inc;
                    if (w_tick_to) begin
                        r_state   <= ST_DONE;
                        r_timeout <= 1'b1;
                    end else if (w_stop_edge) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef REACTION_BEST_SCORE_EN
    logic [ELAPSED_W-1:0] r_best_time;
    logic                 r_best_valid;
    logic [ELAPSED_W-1:0] w_elapsed_nxt;
    logic                 w_best_upd;

    assign w_elapsed_nxt = tick_100th ? w_elapsed_inc : r_elapsed;
    // Only a stop-terminated run enters DONE without timeout.
    assign w_best_upd = (r_state == ST_TIMING) && w_stop_edge && !w_tick_to &&
                        (!r_best_valid || (w_elapsed_nxt < r_best_time));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_best_time  <= '0;
            r_best_valid <= 1'b0;
        end else if (w_best_upd) begin
            r_best_time  <= w_elapsed_nxt;
            r_best_valid <= 1'b1;
        end
    end

    assign best_time  = r_best_time;
    assign best_valid = r_best_valid;
`endif

    assign waiting      = (r_state == ST_DELAY);
    assign test_active  = (r_state == ST_TIMING);
    assign result_valid = (r_state == ST_DONE);
    assign foul         = (r_state == ST_FOUL);
    assign timeout      = r_timeout;
    assign bcd_clear    = r_bcd_clear;
    assign elapsed      = r_elapsed;
    assign bcd_enable   = tick_100th & (r_state == ST_TIMING);

endmodule

// File: tb/tb_reaction_sequencer.sv
module tb_reaction_sequencer;

    localparam int          MIN  = 4;
    localparam int          RB   = 2;
    localparam int          TO   = 30;
    localparam logic [15:0] SEED = 16'hACE1;

    // Reference-model phases
    localparam int P_IDLE = 0, P_DELAY = 1, P_TIMING = 2, P_DONE = 3, P_FOUL = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        request_test = 1'b0;
    logic        stop_test = 1'b0;
    logic        tick_100th = 1'b0;
    logic        waiting, test_active, bcd_clear, bcd_enable;
    logic        result_valid, timeout, foul;
    logic [13:0] elapsed;
`ifdef REACTION_BEST_SCORE_EN
    logic [13:0] best_time;
    logic        best_valid;
`endif

    reaction_sequencer #(
        .MIN_DELAY_TICKS (MIN),
        .RAND_BITS       (RB),
        .TIMEOUT_TICKS   (TO),
        .LFSR_SEED       (SEED)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .request_test (request_test),
        .stop_test    (stop_test),
        .tick_100th   (tick_100th),
        .waiting      (waiting),
        .test_active  (test_active),
        .bcd_clear    (bcd_clear),
        .bcd_enable   (bcd_enable),
        .result_valid (result_valid),
        .timeout      (timeout),
        .foul         (foul),
        .elapsed      (elapsed)
`ifdef REACTION_BEST_SCORE_EN
        ,
        .best_time    (best_time),
        .best_valid   (best_valid)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk = 0;
    int n_err = 0;
    int en_cnt = 0;

    // ---------------- reference model ----------------
    int        m_ph;
    bit [15:0] m_lfsr;
    bit        m_rq_q, m_sp_q, m_clear, m_to, m_bv;
    int        m_left, m_el, m_best;

    task automatic model_reset();
        m_ph = P_IDLE; m_lfsr = SEED; m_rq_q = 0; m_sp_q = 0;
        m_clear = 0; m_to = 0; m_left = 0; m_el = 0; m_best = 0; m_bv = 0;
    endtask

    task automatic model_clk(input bit rq, input bit sp, input bit tk);
        bit re, se;
        re = rq && !m_rq_q;
        se = sp && !m_sp_q;
        m_clear = 0;
        if (m_ph == P_IDLE || m_ph == P_DONE || m_ph == P_FOUL) begin
            if (re) begin
                m_ph = P_DELAY; m_left = MIN + int'(m_lfsr[RB-1:0]);
                m_el = 0; m_to = 0; m_clear = 1;
            end
        end else if (m_ph == P_DELAY) begin
            if (se) m_ph = P_FOUL;
            else if (tk) begin
                m_left = m_left - 1;
                if (m_left == 0) m_ph = P_TIMING;
            end
        end else begin
            if (tk) m_el = m_el + 1;
            if (m_el == TO) begin
                m_ph = P_DONE; m_to = 1;
            end else if (se) begin
                m_ph = P_DONE;
                if (!m_bv || m_el < m_best) begin m_best = m_el; m_bv = 1; end
            end
        end
        m_rq_q = rq; m_sp_q = sp;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at edge+1, check comb enable, advance, check state.
    task automatic step(input bit rq, input bit sp, input bit tk);
        logic [19:0] e;
        request_test = rq; stop_test = sp; tick_100th = tk;
        #1;
        chk("bcd_enable", 32'(bcd_enable), 32'((m_ph == P_TIMING) && tk));
        if (bcd_enable === 1'b1) en_cnt++;
        @(posedge CLOCK_50);
        if (reset) model_reset();
        else model_clk(rq, sp, tk);
        #1;
        e = {m_ph == P_DELAY, m_ph == P_TIMING, m_clear, m_ph == P_DONE, m_to,
             m_ph == P_FOUL, 14'(m_el)};
        chk("outputs", 32'({waiting, test_active, bcd_clear, result_valid, timeout, foul, elapsed}),
            32'(e));
`ifdef REACTION_BEST_SCORE_EN
        chk("best", 32'({best_valid, best_time}), 32'({m_bv, 14'(m_best)}));
`endif
    endtask

    task automatic tick_step(input bit sp);
        repeat (9) step(0, 0, 0);
        step(0, sp, 1);
    endtask

    // dstop: -1 no stop in DELAY, -2 stop on final DELAY tick, k>=0 stop after k ticks
    typedef struct {
        string name;
        int    dstop;
        int    run;
        bit    coinc;
        bit    e_foul;
        bit    e_valid;
        bit    e_to;
        int    e_el;
        int    e_en;
    } vec_t;

    vec_t tbl[6];

    task automatic run_row(input vec_t v, input bit first);
        int d, nt;
        d = MIN + int'(m_lfsr[RB-1:0]);
        step(1, 0, 0);
        chk({v.name, ":clear"}, 32'(bcd_clear), 32'd1);
        chk({v.name, ":wait"}, 32'({waiting, foul, result_valid}), 32'b100);
        step(0, 0, 0);
        chk({v.name, ":clear_end"}, 32'(bcd_clear), 32'd0);
        en_cnt = 0;
        nt = 0;
        while (waiting === 1'b1 && nt < 20) begin
            if (v.dstop >= 0 && nt == v.dstop) break;
            nt++;
            tick_step(v.dstop == -2 && nt == d);
            if (v.dstop == -2 && nt == d) break;
        end
        if (v.dstop == -1) begin
            chk({v.name, ":delay_ticks"}, 32'(nt), 32'(d));
            if (first) chk({v.name, ":first_delay"}, 32'(nt), 32'd7);
            chk({v.name, ":go"}, 32'({test_active, waiting}), 32'b10);
            for (int k = 1; k <= v.run; k++) tick_step(v.coinc && k == v.run);
            if (!v.coinc) begin step(0, 0, 0); step(0, 1, 0); end
        end else if (v.dstop >= 0) begin
            step(0, 0, 0); step(0, 1, 0);
        end
        step(0, 0, 0); step(0, 0, 0);
        chk({v.name, ":foul"}, 32'(foul), 32'(v.e_foul));
        chk({v.name, ":valid"}, 32'(result_valid), 32'(v.e_valid));
        chk({v.name, ":timeout"}, 32'(timeout), 32'(v.e_to));
        chk({v.name, ":elapsed"}, 32'(elapsed), 32'(v.e_el));
        chk({v.name, ":enables"}, 32'(en_cnt), 32'(v.e_en));
        chk({v.name, ":idle_flags"}, 32'({test_active, waiting}), 32'b00);
    endtask

    initial begin
        bit rq, sp, tk;
        int nt;
        tbl[0] = '{"done25",   -1, 25, 1'b0, 1'b0, 1'b1, 1'b0, 25, 25};
        tbl[1] = '{"foul2",     2,  0, 1'b0, 1'b1, 1'b0, 1'b0,  0,  0};
        tbl[2] = '{"timeout",  -1, 30, 1'b0, 1'b0, 1'b1, 1'b1, 30, 30};
        tbl[3] = '{"coinc10",  -1, 10, 1'b1, 1'b0, 1'b1, 1'b0, 10, 10};
        tbl[4] = '{"foulfinal",-2,  0, 1'b0, 1'b1, 1'b0, 1'b0,  0,  0};
        tbl[5] = '{"done18",   -1, 18, 1'b0, 1'b0, 1'b1, 1'b0, 18, 18};

        reset = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        model_reset();
        chk("reset_outputs",
            32'({waiting, test_active, bcd_clear, bcd_enable, result_valid, timeout, foul, elapsed}),
            32'd0);
        reset = 1'b0;
        step(0, 0, 0);

        // First test starts with LFSR[1:0]==3 -> 7-tick delay
        for (int i = 0; i < 100 && m_lfsr[1:0] != 2'd3; i++) step(0, 0, 0);
        for (int r = 0; r < 6; r++) run_row(tbl[r], r == 0);
`ifdef REACTION_BEST_SCORE_EN
        chk("best_time", 32'(best_time), 32'd10);
        chk("best_valid", 32'(best_valid), 32'd1);
`endif

        // Reset while timing at elapsed=12
        step(1, 0, 0);
        step(0, 0, 0);
        nt = 0;
        while (waiting === 1'b1 && nt < 20) begin nt++; tick_step(0); end
        for (int k = 0; k < 12; k++) tick_step(0);
        chk("pre_reset_elapsed", 32'(elapsed), 32'd12);
        reset = 1'b1;
        step(0, 0, 0);
        chk("mid_reset", 32'({waiting, test_active, bcd_clear, result_valid, timeout, foul, elapsed}),
            32'd0);
        reset = 1'b0;
        step(0, 0, 0);
        chk("after_reset", 32'({waiting, test_active, bcd_clear, result_valid, timeout, foul, elapsed}),
            32'd0);

        // Randomized run against the model
        rq = 0; sp = 0;
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 59) == 0) rq = ~rq;
            if ($urandom_range(0, 39) == 0) sp = ~sp;
            tk = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 999) == 0);
            step(rq, sp, tk);
        end
        reset = 1'b0;
        step(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
